// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU-side types, including the RAM status encoding.
package cpu_types_pkg;
    typedef enum logic [1:0] {
        FREE   = 2'b00,
        BUSY   = 2'b01,
        ACCESS = 2'b10,
        ERROR  = 2'b11
    } ramstate_t;
endpackage

// File: rtl/diaosi_types_pkg.sv
// diaosi_types_pkg: memory arbiter FSM state encoding.
package diaosi_types_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        IGNT = 2'b01,
        DGNT = 2'b10
    } arb_state_t;
endpackage

// File: rtl/arb_starve_counter.sv
// arb_starve_counter: saturating count of dcache grants completed while the icache waits.
module arb_starve_counter #(
    parameter int STARVE_MAX = 4
) (
    input  logic CLK,
    input  logic nRST,
    input  logic inc,
    input  logic clr,
    output logic sat
);
    localparam int W = $clog2(STARVE_MAX + 1);
    logic [W-1:0] cnt;
    always_ff @(posedge CLK, negedge nRST) begin
        if (!nRST)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && !sat)
            cnt <= cnt + 1'b1;
    end
    assign sat = cnt == W'(STARVE_MAX);
endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter: arbitrates icache and dcache onto one RAM port, dcache first,
// with a starvation limit that forces an icache grant.
import cpu_types_pkg::*;
import diaosi_types_pkg::*;
module memory_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic [31:0] iload,
    output logic        iwait,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic [31:0] dload,
    output logic        dwait,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate
);
    arb_state_t state, next_state;
    logic acc, dact, sat;
    assign acc  = ramstate == ACCESS;
    assign dact = dREN || dWEN;
    assign iload = ramload;
    assign dload = ramload;
    arb_starve_counter #(.STARVE_MAX(STARVE_MAX)) u_starve (
        .CLK  (CLK),
        .nRST (nRST),
        .inc  (state == DGNT && dact && acc && iREN),
        .clr  (!iREN || (state == IGNT && acc)),
        .sat  (sat)
    );
    always_ff @(posedge CLK, negedge nRST) begin
        if (!nRST)
            state <= IDLE;
        else
            state <= next_state;
    end
    // A grant ends on completion or when its requester drops the enable (abort).
    always_comb begin
        next_state = state;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;
        iwait      = 1'b1;
        dwait      = 1'b1;
        case (state)
            IDLE: next_state = (iREN && sat) ? IGNT : dact ? DGNT : iREN ? IGNT : IDLE;
            IGNT: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                iwait   = !(iREN && acc);
                if (!iREN || acc)
                    next_state = IDLE;
            end
            DGNT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN && !dWEN;
                dwait    = !(dact && acc);
                if (!dact || acc)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed scenarios plus randomized traffic checked against a
// transaction-level model of the arbitration rules.
module tb_memory_arbiter;
    localparam int SMAX = 4;
    localparam logic [1:0] RS_FREE = 2'd0, RS_BUSY = 2'd1, RS_ACC = 2'd2, RS_ERR = 2'd3;
    logic CLK = 1'b0, nRST = 1'b0;
    logic iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
    logic [31:0] iaddr = '0, daddr = '0, dstore = '0, ramload = '0;
    logic [1:0] ramstate = RS_FREE;
    logic [31:0] iload, dload, ramaddr, ramstore;
    logic iwait, dwait, ramREN, ramWEN;
    int errors = 0, checks = 0;
    int owner = 0;
    int starve = 0;
    int log_q[$];

    memory_arbiter #(.STARVE_MAX(SMAX)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dwait(dwait),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // owner: 0 = nobody, 1 = icache, 2 = dcache. Called at a falling edge with inputs set.
    task automatic step;
        bit acc, dact, done;
        int nxt;
        #1;
        acc  = ramstate == RS_ACC;
        dact = dREN || dWEN;
        chk("ramREN", ramREN, owner == 1 ? iREN : owner == 2 ? (dREN && !dWEN) : 1'b0);
        chk("ramWEN", ramWEN, owner == 2 && dWEN);
        chk("ramaddr", ramaddr, owner == 1 ? iaddr : owner == 2 ? daddr : 32'd0);
        if (owner != 1)
            chk("ramstore", ramstore, owner == 2 ? dstore : 32'd0);
        chk("iwait", iwait, !(owner == 1 && iREN && acc));
        chk("dwait", dwait, !(owner == 2 && dact && acc));
        chk("iload", iload, ramload);
        chk("dload", dload, ramload);
        if (iwait === 1'b0) log_q.push_back(1);
        if (dwait === 1'b0) log_q.push_back(2);
        if (owner == 0)
            nxt = (iREN && starve == SMAX) ? 1 : dact ? 2 : iREN ? 1 : 0;
        else begin
            done = owner == 1 ? !iREN || acc : !dact || acc;
            nxt  = done ? 0 : owner;
        end
        if (!iREN)
            starve = 0;
        else if (owner == 1 && acc)
            starve = 0;
        else if (owner == 2 && dact && acc)
            starve = starve < SMAX ? starve + 1 : SMAX;
        @(posedge CLK);
        owner = nxt;
        @(negedge CLK);
    endtask

    task automatic rst_pulse;
        nRST = 1'b0;
        #1;
        chk("rst_ramREN", ramREN, 1'b0);
        chk("rst_ramWEN", ramWEN, 1'b0);
        chk("rst_iwait", iwait, 1'b1);
        chk("rst_dwait", dwait, 1'b1);
        chk("rst_starve", dut.u_starve.cnt, 0);
        owner  = 0;
        starve = 0;
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    initial begin
        int exp37[6] = '{2, 2, 2, 2, 1, 2};
        @(negedge CLK);
        rst_pulse();
        // icache read: enable from cycle 1, completion in cycle 2, IDLE in cycle 3
        iREN = 1; iaddr = 32'h40; ramstate = RS_FREE;
        #1 chk("r035_c0_ren", ramREN, 1'b0);
        step();
        ramstate = RS_BUSY;
        #1 chk("r035_c1_ren", ramREN, 1'b1);
        chk("r035_c1_addr", ramaddr, 32'h40);
        step();
        ramstate = RS_ACC; ramload = 32'h1234_5678;
        #1 chk("r035_c2_iwait", iwait, 1'b0);
        chk("r035_c2_iload", iload, 32'h1234_5678);
        step();
        #1 chk("r035_c3_idle", ramREN, 1'b0);
        step();
        iREN = 0; step();
        // simultaneous icache read and dcache write: dcache first, then icache
        iREN = 1; dWEN = 1; daddr = 32'h100; dstore = 32'hDEAD_BEEF; iaddr = 32'h44;
        ramstate = RS_ACC;
        step();
        #1 chk("r036_wen", ramWEN, 1'b1);
        chk("r036_ren", ramREN, 1'b0);
        chk("r036_store", ramstore, 32'hDEAD_BEEF);
        chk("r036_dwait", dwait, 1'b0);
        step();
        dWEN = 0;
        step();
        #1 chk("r036_iren", ramREN, 1'b1);
        chk("r036_iaddr", ramaddr, 32'h44);
        chk("r036_iwait", iwait, 1'b0);
        step();
        iREN = 0; step();
        // starvation: four dcache completions, then icache, then dcache
        log_q.delete();
        iREN = 1; dREN = 1; ramstate = RS_ACC;
        repeat (12) step();
        chk("r037_n", log_q.size(), 6);
        for (int k = 0; k < 6; k++) chk($sformatf("r037_seq%0d", k), log_q[k], exp37[k]);
        iREN = 0; dREN = 0; step();
        // ERROR retries: a single completion with the address held
        log_q.delete();
        iREN = 1; iaddr = 32'h80; ramstate = RS_FREE; step();
        ramstate = RS_ERR; repeat (3) step();
        ramstate = RS_ACC; step();
        iREN = 0; ramstate = RS_FREE; step();
        chk("r038_n", log_q.size(), 1);
        // dcache abort under BUSY
        dREN = 1; daddr = 32'h200; step();
        ramstate = RS_BUSY; step();
        dREN = 0;
        #1 chk("r039_ren", ramREN, 1'b0);
        chk("r039_dwait", dwait, 1'b1);
        step();
        dREN = 1;
        #1 chk("r039_idle", ramREN, 1'b0);
        step();
        dREN = 0; step();
        // reset during an icache grant after building a starvation count
        iREN = 1; dREN = 1; ramstate = RS_ACC; repeat (4) step();
        dREN = 0; ramstate = RS_BUSY; step(); step();
        rst_pulse();
        #1 chk("r040_idle_ren", ramREN, 1'b0);
        step();
        iREN = 0; step();
        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            int r;
            if ($urandom_range(0, 7) == 0) iREN = ~iREN;
            if ($urandom_range(0, 7) == 0) dREN = ~dREN;
            if ($urandom_range(0, 9) == 0) dWEN = ~dWEN;
            if ($urandom_range(0, 3) == 0) iaddr = $urandom;
            if ($urandom_range(0, 3) == 0) daddr = $urandom;
            if ($urandom_range(0, 3) == 0) dstore = $urandom;
            ramload = $urandom;
            r = $urandom_range(0, 7);
            ramstate = r < 3 ? RS_ACC : r < 5 ? RS_BUSY : r < 6 ? RS_ERR : RS_FREE;
            if ($urandom_range(0, 199) == 0)
                rst_pulse();
            else
                step();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
